// File: rtl/sr_latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sr_latch_bank_sequencer
// Desc    : Round-robin write sequencer for a shared bank of NAND SR latches.
//           Drives timed active-low set/reset pulses; s_n=r_n=0 is never driven.
// Options : SR_SEQ_READBACK_VERIFY_EN - read back latch_q after recovery, one retry
// Rev     : 1.0  initial release
// ============================================================================

module sr_latch_bank_sequencer #(
    parameter int N_CELLS        = 8,
    parameter int ADDR_W         = 3,
    parameter int PULSE_CYCLES   = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic               req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic               req1_data,
    output logic [N_CELLS-1:0] latch_s_n,
    output logic [N_CELLS-1:0] latch_r_n,
    input  logic [N_CELLS-1:0] latch_q,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic               err
);

    localparam int c_cnt_max = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_recov_last = c_cnt_w'(RECOVER_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic               r_data, w_data_nxt;
    logic               r_id, w_id_nxt;
    logic               r_ptr, w_ptr_nxt;
    logic               r_oor, w_oor_nxt;
    logic               r_retry, w_retry_nxt;
    logic [N_CELLS-1:0] r_s_n, w_s_n_nxt;
    logic [N_CELLS-1:0] r_r_n, w_r_n_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_done_id, w_done_id_nxt;
    logic               r_err, w_err_nxt;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_sel_data;
    logic               w_sel_in_range;
    logic [N_CELLS-1:0] w_sel_mask;
    logic [N_CELLS-1:0] w_cap_mask;
    logic               w_rb_bad;

    // One-hot cell select; an out-of-range address selects nothing.
    function automatic logic [N_CELLS-1:0] f_cell_mask(input logic [ADDR_W-1:0] addr);
        logic [N_CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (32'(addr) == i) m[i] = 1'b1;
        end
        return m;
    endfunction

    assign w_idle         = (r_state == ST_IDLE);
    assign w_gnt0         = w_idle & req0_valid & (~req1_valid | ~r_ptr);
    assign w_gnt1         = w_idle & req1_valid & (~req0_valid |  r_ptr);
    assign w_accept       = w_gnt0 | w_gnt1;
    assign w_sel_addr     = w_gnt1 ? req1_addr : req0_addr;
    assign w_sel_data     = w_gnt1 ? req1_data : req0_data;
    assign w_sel_in_range = (32'(w_sel_addr) < 32'(N_CELLS));
    assign w_sel_mask     = f_cell_mask(w_sel_addr);
    assign w_cap_mask     = f_cell_mask(r_addr);

`ifdef SR_SEQ_READBACK_VERIFY_EN
    assign w_rb_bad = ~r_oor & ((|(latch_q & w_cap_mask)) != r_data);
`else
    logic w_unused_q;
    assign w_unused_q = ^latch_q;
    assign w_rb_bad   = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_id_nxt      = r_id;
        w_ptr_nxt     = r_ptr;
        w_oor_nxt     = r_oor;
        w_retry_nxt   = r_retry;
        w_s_n_nxt     = '1;
        w_r_n_nxt     = '1;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = w_sel_addr;
                    w_data_nxt  = w_sel_data;
                    w_id_nxt    = w_gnt1;
                    w_oor_nxt   = ~w_sel_in_range;
                    w_retry_nxt = 1'b0;
                    if (req0_valid & req1_valid) w_ptr_nxt = ~r_ptr;
                    // Only one of the two vectors ever carries the low bit.
                    w_s_n_nxt   = w_sel_data ? ~w_sel_mask : '1;
                    w_r_n_nxt   = w_sel_data ? '1 : ~w_sel_mask;
                end
            end
            ST_PULSE: begin
                if (r_cnt == c_pulse_last) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    w_s_n_nxt = r_s_n;
                    w_r_n_nxt = r_r_n;
                end
            end
            ST_RECOVER: begin
                if (r_cnt != c_recov_last) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end else if (w_rb_bad & ~r_retry) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 1'b1;
                    w_s_n_nxt   = r_data ? ~w_cap_mask : '1;
                    w_r_n_nxt   = r_data ? '1 : ~w_cap_mask;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_id;
                    w_err_nxt     = r_oor | w_rb_bad;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= 1'b0;
            r_id      <= 1'b0;
            r_ptr     <= 1'b0;
            r_oor     <= 1'b0;
            r_retry   <= 1'b0;
            r_s_n     <= '1;
            r_r_n     <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_id      <= w_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_oor     <= w_oor_nxt;
            r_retry   <= w_retry_nxt;
            r_s_n     <= w_s_n_nxt;
            r_r_n     <= w_r_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign latch_s_n  = r_s_n;
    assign latch_r_n  = r_r_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sr_latch_bank_sequencer
// Desc    : Self-checking bench for sr_latch_bank_sequencer (6-cell bank so that
//           out-of-range addresses are reachable); NAND latch cells modelled here.
// Rev     : 1.0  initial release
// ============================================================================

module tb_sr_latch_bank_sequencer;

    localparam int N  = 6;
    localparam int AW = 3;
    localparam int P  = 2;
    localparam int R  = 1;
    localparam int L  = P + R;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid, req0_data, req1_valid, req1_data;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_ready, req1_ready;
    logic [N-1:0]  latch_s_n, latch_r_n, latch_q;
    logic          busy, done, done_id, err;

    logic [N-1:0]  q_model     = '0;
    logic [N-1:0]  q_force_low = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_latch_bank_sequencer #(
        .N_CELLS        (N),
        .ADDR_W         (AW),
        .PULSE_CYCLES   (P),
        .RECOVER_CYCLES (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .latch_s_n  (latch_s_n),
        .latch_r_n  (latch_r_n),
        .latch_q    (latch_q),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .err        (err)
    );

    // NAND SR cell: low s_n sets, low r_n clears, both high holds.
    always @(latch_s_n or latch_r_n) begin
        for (int i = 0; i < N; i++) begin
            if (latch_s_n[i] === 1'b0)      q_model[i] = 1'b1;
            else if (latch_r_n[i] === 1'b0) q_model[i] = 1'b0;
        end
    end
    assign latch_q = q_model & ~q_force_low;

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (latch_s_n !== '1 || latch_r_n !== '1 || busy !== 1'b0 || done !== 1'b0 ||
            done_id !== 1'b0 || err !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: s_n=%b r_n=%b busy=%b done=%b done_id=%b err=%b rdy=%b%b, want s_n/r_n all ones, rest 0",
                     latch_s_n, latch_r_n, busy, done, done_id, err, req0_ready, req1_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 1'b1;
        edge1(); req0_valid = 1'b0;
        n_vec++;
        if (latch_s_n !== 6'b111011 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prepulse: s_n=%b busy=%b, want 111011 1", latch_s_n, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (latch_s_n !== '1 || latch_r_n !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: s_n=%b r_n=%b busy=%b done=%b, want all ones, 0, 0",
                     latch_s_n, latch_r_n, busy, done);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_write();
        logic [N-1:0] exp_s;
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        edge1(); req0_valid = 1'b0;
        for (int k = 0; k <= L; k++) begin
            exp_s = (k < P) ? 6'b011111 : 6'b111111;
            n_vec++;
            if (latch_s_n !== exp_s || latch_r_n !== '1 || busy !== (k < L) || done !== (k == L) ||
                (k == L && (done_id !== 1'b0 || err !== 1'b0))) begin
                n_err++;
                $display("FAIL single_k%0d: s_n=%b r_n=%b busy=%b done=%b id=%b err=%b, want s_n=%b r_n=111111 busy=%b done=%b id=0 err=0",
                         k, latch_s_n, latch_r_n, busy, done, done_id, err, exp_s, (k < L), (k == L));
            end
            if (k < L) edge1();
        end
        n_vec++;
        if (latch_q[5] !== 1'b1) begin
            n_err++;
            $display("FAIL single_cell_q: q5=%b, want 1", latch_q[5]);
        end
    endtask

    task automatic test_contention();
        logic         exp_id;
        logic [N-1:0] exp_s, exp_r;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 1'b1;
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 1'b0;
        exp_id = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            n_vec++;
            if (req0_ready !== (exp_id == 1'b0) || req1_ready !== (exp_id == 1'b1)) begin
                n_err++;
                $display("FAIL contention_grant%0d: rdy0=%b rdy1=%b, want grant to %0d", w, req0_ready, req1_ready, exp_id);
            end
            edge1();
            for (int k = 0; k <= L; k++) begin
                exp_s = '1; exp_r = '1;
                if (k < P) begin
                    if (exp_id == 1'b0) exp_s[1] = 1'b0;
                    else                exp_r[4] = 1'b0;
                end
                n_vec++;
                if (latch_s_n !== exp_s || latch_r_n !== exp_r || ((~latch_s_n & ~latch_r_n) != '0) ||
                    done !== (k == L) || (k == L && done_id !== exp_id)) begin
                    n_err++;
                    $display("FAIL contention_w%0d_k%0d: s_n=%b r_n=%b done=%b id=%b, want s_n=%b r_n=%b done=%b id=%b",
                             w, k, latch_s_n, latch_r_n, done, done_id, exp_s, exp_r, (k == L), exp_id);
                end
                if (k < L) edge1();
            end
            exp_id = ~exp_id;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        do_reset();
        @(negedge clk); req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 1'b1;
        #1;
        n_vec++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL oor_ready: rdy0=%b rdy1=%b, want 0 1", req0_ready, req1_ready);
        end
        edge1(); req1_valid = 1'b0;
        for (int k = 0; k <= L; k++) begin
            n_vec++;
            if (latch_s_n !== '1 || latch_r_n !== '1 || busy !== (k < L) || done !== (k == L) ||
                err !== (k == L) || (k == L && done_id !== 1'b1)) begin
                n_err++;
                $display("FAIL oor_k%0d: s_n=%b r_n=%b busy=%b done=%b err=%b id=%b, want ones ones busy=%b done=%b err=%b id=1",
                         k, latch_s_n, latch_r_n, busy, done, err, done_id, (k < L), (k == L), (k == L));
            end
            if (k < L) edge1();
        end
    endtask

    task automatic test_mid_pulse_reset();
        do_reset();
        @(negedge clk); req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 1'b0;
        edge1(); req0_valid = 1'b0;
        n_vec++;
        if (latch_r_n !== 6'b110111 || latch_s_n !== '1) begin
            n_err++;
            $display("FAIL midrst_pulse: s_n=%b r_n=%b, want 111111 110111", latch_s_n, latch_r_n);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (latch_s_n !== '1 || latch_r_n !== '1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_release: s_n=%b r_n=%b busy=%b, want ones ones 0", latch_s_n, latch_r_n, busy);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < L + 2; k++) begin
            edge1();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || latch_s_n !== '1 || latch_r_n !== '1) begin
                n_err++;
                $display("FAIL midrst_quiet%0d: done=%b busy=%b s_n=%b r_n=%b, want 0 0 ones ones",
                         k, done, busy, latch_s_n, latch_r_n);
            end
        end
        @(negedge clk); req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 1'b1;
        edge1(); req1_valid = 1'b0;
        for (int k = 0; k <= L; k++) begin
            n_vec++;
            if (latch_s_n !== ((k < P) ? 6'b111110 : 6'b111111) || done !== (k == L) ||
                (k == L && (done_id !== 1'b1 || err !== 1'b0))) begin
                n_err++;
                $display("FAIL midrst_next_k%0d: s_n=%b done=%b id=%b err=%b, want done=%b id=1 err=0",
                         k, latch_s_n, done, done_id, err, (k == L));
            end
            if (k < L) edge1();
        end
    endtask

`ifdef SR_SEQ_READBACK_VERIFY_EN
    task automatic test_verify();
        logic [N-1:0] exp_s;
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            q_force_low = 6'b000100;
            @(negedge clk); req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 1'b1;
            edge1(); req0_valid = 1'b0;
            for (int k = 0; k <= 2 * L; k++) begin
                exp_s = ((k < P) || (k >= L && k < L + P)) ? 6'b111011 : 6'b111111;
                n_vec++;
                if (latch_s_n !== exp_s || latch_r_n !== '1 || done !== (k == 2 * L) ||
                    (k == 2 * L && err !== (sc == 1))) begin
                    n_err++;
                    $display("FAIL verify_s%0d_k%0d: s_n=%b r_n=%b done=%b err=%b, want s_n=%b done=%b err=%b",
                             sc, k, latch_s_n, latch_r_n, done, err, exp_s, (k == 2 * L), (sc == 1));
                end
                if (k == L && sc == 0) q_force_low = '0;
                if (k < 2 * L) edge1();
            end
            q_force_low = '0;
        end
    endtask
`endif

    task automatic test_random();
        int            t_acc, cyc, k;
        logic          m_ptr, m_id, m_data, g0, g1, idle;
        logic          e_busy, e_done, e_err;
        logic [AW-1:0] m_addr;
        logic [N-1:0]  es, er;
        do_reset();
        t_acc = -1; cyc = 0; m_ptr = 1'b0; m_id = 1'b0; m_data = 1'b0; m_addr = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!req0_valid || $urandom_range(3) == 0) begin
                req0_valid = 1'($urandom_range(1));
                req0_addr  = AW'($urandom_range(7));
                req0_data  = 1'($urandom_range(1));
            end
            if (!req1_valid || $urandom_range(3) == 0) begin
                req1_valid = 1'($urandom_range(1));
                req1_addr  = AW'($urandom_range(7));
                req1_data  = 1'($urandom_range(1));
            end
            #1;
            idle = (t_acc < 0) || (cyc - t_acc >= L);
            g0 = idle && req0_valid && (!req1_valid || !m_ptr);
            g1 = idle && req1_valid && (!req0_valid ||  m_ptr);
            n_vec++;
            if (req0_ready !== g0 || req1_ready !== g1) begin
                n_err++;
                $display("FAIL rand_grant%0d: rdy0=%b rdy1=%b, want %b %b", i, req0_ready, req1_ready, g0, g1);
            end
            @(posedge clk); #1;
            cyc++;
            if (g0 || g1) begin
                t_acc  = cyc;
                m_id   = g1;
                m_addr = g1 ? req1_addr : req0_addr;
                m_data = g1 ? req1_data : req0_data;
                if (req0_valid && req1_valid) m_ptr = !m_ptr;
            end
            es = '1; er = '1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            if (t_acc >= 0) begin
                k = cyc - t_acc;
                if (k < P && m_addr < N) begin
                    if (m_data) es[m_addr] = 1'b0;
                    else        er[m_addr] = 1'b0;
                end
                e_busy = (k < L);
                e_done = (k == L);
                e_err  = e_done && (m_addr >= N);
            end
            n_vec++;
            if (latch_s_n !== es || latch_r_n !== er || busy !== e_busy || done !== e_done ||
                err !== e_err || (e_done && done_id !== m_id)) begin
                n_err++;
                $display("FAIL rand_out%0d: s_n=%b r_n=%b busy=%b done=%b id=%b err=%b, want %b %b %b %b %b %b",
                         i, latch_s_n, latch_r_n, busy, done, done_id, err, es, er, e_busy, e_done, m_id, e_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_out_of_range();
        test_mid_pulse_reset();
`ifdef SR_SEQ_READBACK_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
